operand_loader: RTL and testbench

- Writer side of the operand input path. Takes one operand set from the host/testbench through a valid/ready handshake.
- Serializes the operand set into byte writes to the operand region of data memory, in the byte order the core's loads (lw Rx, RIM) read it back.
- Then pulses Start to the core and waits for Done. Flags a zero divisor at capture time, so host and core-side checks agree.

---
 rtl/operand_loader_pkg.sv | 36 +++
 rtl/operand_loader_if.sv | 29 ++
 rtl/operand_loader_byte_mux.sv | 27 ++
 rtl/operand_loader.sv | 125 ++++++++++++
 tb/tb_operand_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
//   prog_state_t   : host program selector encoding
//   loader_state_t : loader FSM states
//   *_NBYTES       : operand bytes written per program
//   nbytes()       : program -> byte count
package prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PROG1 = 2'b01,
        PROG2 = 2'b10,
        PROG3 = 2'b11
    } prog_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_START,
        ST_WAIT_DONE
    } loader_state_t;

    localparam logic [2:0] PROG1_NBYTES = 3'd4;
    localparam logic [2:0] PROG2_NBYTES = 3'd3;
    localparam logic [2:0] PROG3_NBYTES = 3'd2;

    // An IDLE program can only be captured if ProgState drops in the very
    // cycle of the handshake; it is then treated like prog3 (dividend only).
    function automatic logic [2:0] nbytes(input prog_state_t p);
        case (p)
            PROG1:   nbytes = PROG1_NBYTES;
            PROG2:   nbytes = PROG2_NBYTES;
            default: nbytes = PROG3_NBYTES;
        endcase
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Host/core/memory signal bundle of the operand loader.
//   master : host side (drives program, operands, Done)
//   slave  : loader side (drives ready, memory writes, Start, status)
interface operand_loader_if #(
    parameter int ADDR_W = 8
);
    logic [1:0]        ProgState;
    logic              OpValid;
    logic              OpReady;
    logic [15:0]       Dividend;
    logic [15:0]       Divisor;
    logic              MemWrEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemDataOut;
    logic              Start;
    logic              Done;
    logic              DivZero;
    logic              Busy;

    modport master (
        output ProgState, OpValid, Dividend, Divisor, Done,
        input  OpReady, MemWrEn, MemAddr, MemDataOut, Start, DivZero, Busy
    );

    modport slave (
        input  ProgState, OpValid, Dividend, Divisor, Done,
        output OpReady, MemWrEn, MemAddr, MemDataOut, Start, DivZero, Busy
    );
endinterface

// File: rtl/operand_loader_byte_mux.sv
// Combinational byte select for the operand write burst.
//   dividend, divisor : captured operands
//   prog              : captured program
//   idx               : byte index k within the burst
//   data              : byte to write at BASE_ADDR + k
// Order matches what the core's loads expect: dividend MSB, dividend LSB,
// then divisor MSB/LSB (prog1) or divisor LSB only (prog2).
module operand_byte_mux
    import prog_pkg::*;
(
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    input  prog_state_t prog,
    input  logic [1:0]  idx,
    output logic [7:0]  data
);
    always_comb begin
        data = 8'h00;
        case (idx)
            2'd0: data = dividend[15:8];
            2'd1: data = dividend[7:0];
            2'd2: data = (prog == PROG1) ? divisor[15:8] : divisor[7:0];
            2'd3: data = divisor[7:0];
            default: data = 8'h00;
        endcase
    end
endmodule

// File: rtl/operand_loader.sv
// Operand loader: accepts one operand set over a valid/ready handshake,
// writes it byte-serially into data memory, pulses Start to the core and
// waits for Done.
//   CLK, RESET_N : clock, async active-low reset
//   bus (slave)  : ProgState/OpValid/OpReady/Dividend/Divisor host side,
//                  MemWrEn/MemAddr/MemDataOut memory side,
//                  Start/Done core side, DivZero/Busy status
// Every output is a flop; each is loaded from the next-state values so the
// first write appears the cycle right after the handshake.
module operand_loader
    import prog_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(128)
) (
    input  logic         CLK,
    input  logic         RESET_N,
    operand_loader_if.slave bus
);
    loader_state_t state_q, state_n;
    prog_state_t   prog_q, prog_n, prog_in;
    logic [15:0]   dvd_q, dvd_n, dvs_q, dvs_n;
    logic [1:0]    k_q, k_n;
    logic [2:0]    nb_q, nb_n;
    logic          accept;
    logic          wr_n;
    logic [7:0]    byte_n;

    logic              rdy_q, wr_q, start_q, dz_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    assign prog_in = prog_state_t'(bus.ProgState);
    assign accept  = (state_q == ST_IDLE) && bus.OpValid && rdy_q;

    always_comb begin
        state_n = state_q;
        prog_n  = prog_q;
        dvd_n   = dvd_q;
        dvs_n   = dvs_q;
        k_n     = k_q;
        nb_n    = nb_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    prog_n  = prog_in;
                    dvd_n   = bus.Dividend;
                    dvs_n   = bus.Divisor;
                    nb_n    = nbytes(prog_in);
                    k_n     = 2'd0;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if ({1'b0, k_q} == nb_q - 3'd1) state_n = ST_START;
                else                            k_n     = k_q + 2'd1;
            end
            ST_START:     state_n = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.Done) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    assign wr_n = (state_n == ST_WRITE);

    operand_byte_mux u_mux (
        .dividend (dvd_n),
        .divisor  (dvs_n),
        .prog     (prog_n),
        .idx      (k_n),
        .data     (byte_n)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            prog_q  <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            k_q     <= '0;
            nb_q    <= '0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            prog_q  <= prog_n;
            dvd_q   <= dvd_n;
            dvs_q   <= dvs_n;
            k_q     <= k_n;
            nb_q    <= nb_n;
            // Ready follows ProgState with one cycle of lag.
            rdy_q   <= (state_n == ST_IDLE) && (bus.ProgState != 2'b00);
            wr_q    <= wr_n;
            start_q <= (state_n == ST_START);
            busy_q  <= (state_n != ST_IDLE);
            // Address/data hold their last values outside a burst.
            if (wr_n) begin
                addr_q <= BASE_ADDR + ADDR_W'(k_n);
                data_q <= byte_n;
            end
            // Sticky until the next capture.
            if (accept) begin
                case (prog_in)
                    PROG1:   dz_q <= (bus.Divisor == 16'h0000);
                    PROG2:   dz_q <= (bus.Divisor[7:0] == 8'h00);
                    default: dz_q <= 1'b0;
                endcase
            end
        end
    end

    assign bus.OpReady    = rdy_q;
    assign bus.MemWrEn    = wr_q;
    assign bus.MemAddr    = addr_q;
    assign bus.MemDataOut = data_q;
    assign bus.Start      = start_q;
    assign bus.DivZero    = dz_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: two instances (BASE_ADDR 128 and 254) share one
// stimulus stream; expected writes/Starts are queued per instance and a
// monitor per instance checks them as they appear.
module tb_operand_loader;
    import prog_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    operand_loader_if #(.ADDR_W(8)) if0 ();
    operand_loader_if #(.ADDR_W(8)) if1 ();

    assign if1.ProgState = if0.ProgState;
    assign if1.OpValid   = if0.OpValid;
    assign if1.Dividend  = if0.Dividend;
    assign if1.Divisor   = if0.Divisor;
    assign if1.Done      = if0.Done;

    operand_loader #(.ADDR_W(8), .BASE_ADDR(8'd128)) dut0 (.CLK(CLK), .RESET_N(RESET_N), .bus(if0.slave));
    operand_loader #(.ADDR_W(8), .BASE_ADDR(8'd254)) dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(if1.slave));

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit dz;
    } wr_t;

    wr_t wq0[$];
    wr_t wq1[$];
    int  sq0[$];
    int  sq1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit last_dz = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: bytes and flag derived straight from the operand rules.
    function automatic bit model_dz(input int p, input int b);
        if (p == 1) return (b == 0);
        if (p == 2) return ((b % 256) == 0);
        return 1'b0;
    endfunction

    task automatic push_expect(input int p, input int a, input int b, input int h);
        int bl[$];
        bit dz;
        bl.push_back(a / 256);
        bl.push_back(a % 256);
        if (p == 1) begin bl.push_back(b / 256); bl.push_back(b % 256); end
        if (p == 2) bl.push_back(b % 256);
        dz = model_dz(p, b);
        last_dz = dz;
        foreach (bl[k]) begin
            wq0.push_back('{h + k, (128 + k) % 256, bl[k], dz});
            wq1.push_back('{h + k, (254 + k) % 256, bl[k], dz});
        end
        sq0.push_back(h + bl.size());
        sq1.push_back(h + bl.size());
    endtask

    task automatic mon(input int d, input logic wr, input logic [7:0] ad, input logic [7:0] dt,
                       input logic st, input logic dz, input logic busy);
        wr_t e;
        int  s;
        bit  have;
        string tag;
        tag = (d == 0) ? "u0" : "u1";
        if (wr) begin
            have = 1'b0;
            if (d == 0 && wq0.size() > 0) begin e = wq0.pop_front(); have = 1'b1; end
            if (d == 1 && wq1.size() > 0) begin e = wq1.pop_front(); have = 1'b1; end
            if (!have) chk({tag, " unexpected_write"}, 1, 0);
            else begin
                chk({tag, " wr_cycle"}, cyc, e.cyc);
                chk({tag, " wr_addr"}, {24'h0, ad}, e.addr);
                chk({tag, " wr_data"}, {24'h0, dt}, e.data);
                chk({tag, " divzero"}, {31'h0, dz}, {31'h0, e.dz});
                chk({tag, " busy_wr"}, {31'h0, busy}, 1);
                chk({tag, " start_in_wr"}, {31'h0, st}, 0);
            end
        end
        if (st) begin
            have = 1'b0;
            if (d == 0 && sq0.size() > 0) begin s = sq0.pop_front(); have = 1'b1; end
            if (d == 1 && sq1.size() > 0) begin s = sq1.pop_front(); have = 1'b1; end
            if (!have) chk({tag, " unexpected_start"}, 1, 0);
            else       chk({tag, " start_cycle"}, cyc, s);
        end
    endtask

    always @(negedge CLK) if (RESET_N) mon(0, if0.MemWrEn, if0.MemAddr, if0.MemDataOut, if0.Start, if0.DivZero, if0.Busy);
    always @(negedge CLK) if (RESET_N) mon(1, if1.MemWrEn, if1.MemAddr, if1.MemDataOut, if1.Start, if1.DivZero, if1.Busy);

    task automatic chk_zero(input string nm);
        chk({nm, " u0_outs"}, {if0.OpReady, if0.MemWrEn, if0.Start, if0.DivZero, if0.Busy, if0.MemAddr, if0.MemDataOut}, 0);
        chk({nm, " u1_outs"}, {if1.OpReady, if1.MemWrEn, if1.Start, if1.DivZero, if1.Busy, if1.MemAddr, if1.MemDataOut}, 0);
    endtask

    task automatic chk_drained(input string nm);
        chk({nm, " pending"}, wq0.size() + wq1.size() + sq0.size() + sq1.size(), 0);
    endtask

    // Called at a negedge; returns just after the consuming posedge.
    task automatic issue(input int p, input int a, input int b, output bit ok);
        if0.ProgState = 2'(p);
        if0.Dividend  = 16'(a);
        if0.Divisor   = 16'(b);
        if0.OpValid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if0.OpReady) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (!ok) begin
            chk("handshake_timeout", 1, 0);
            if0.OpValid = 1'b0;
        end else begin
            push_expect(p, a, b, cyc + 1);
            @(posedge CLK);
            #1 if0.OpValid = 1'b0;
        end
    endtask

    task automatic finish_set(input bit hold_done, input int dly, input bit early);
        bit seen;
        if (hold_done) if0.Done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (if0.Start) begin seen = 1'b1; break; end
        end
        if (!seen) chk("start_timeout", 1, 0);
        @(negedge CLK);
        if0.Done = 1'b0;
        if (early) if0.OpValid = 1'b1;
        chk("busy_wait", {31'h0, if0.Busy}, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge CLK);
            chk("ready_in_wait", {31'h0, if0.OpReady}, 0);
        end
        if0.Done = 1'b1;
        @(negedge CLK);
        if0.Done = 1'b0;
        chk("ready_after_done", {31'h0, if0.OpReady}, 1);
        chk("busy_after_done", {31'h0, if0.Busy}, 0);
        chk("divzero_sticky", {31'h0, if0.DivZero}, {31'h0, last_dz});
        chk_drained("after_set");
    endtask

    task automatic run(input int p, input int a, input int b, input bit hold_done, input int dly, input bit early);
        bit ok;
        issue(p, a, b, ok);
        if (ok) finish_set(hold_done, dly, early);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int p, a, b;
        if0.ProgState = 2'b00;
        if0.OpValid   = 1'b0;
        if0.Dividend  = '0;
        if0.Divisor   = '0;
        if0.Done      = 1'b0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RESET_N = 1'b1;

        // No program selected: not ready, request not consumed.
        if0.OpValid = 1'b1;
        if0.Dividend = 16'h5555;
        repeat (4) begin
            @(negedge CLK);
            chk("ready_prog_idle", {31'h0, if0.OpReady}, 0);
        end
        if0.OpValid = 1'b0;
        @(negedge CLK);

        run(1, 16'h1234, 16'h0056, 1'b0, 1, 1'b0);
        run(2, 16'hABCD, 16'h00FF, 1'b0, 0, 1'b0);
        run(2, 16'hABCD, 16'hFF00, 1'b0, 2, 1'b0);
        run(1, 16'h0BAD, 16'h0000, 1'b0, 0, 1'b0);
        run(3, 16'hBEEF, 16'h0000, 1'b0, 1, 1'b0);
        run(1, 16'h00FF, 16'h0100, 1'b1, 2, 1'b0);   // Done held over WRITE/START
        run(2, 16'h4242, 16'h1201, 1'b0, 3, 1'b1);   // OpValid raised while busy
        run(3, 16'h7777, 16'h0001, 1'b0, 0, 1'b0);

        // Reset while the second prog1 byte is on the bus.
        issue(1, 16'h1111, 16'h2222, ok);
        @(negedge CLK);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1 chk_zero("reset_mid_write");
        wq0.delete(); wq1.delete(); sq0.delete(); sq1.delete();
        repeat (3) @(negedge CLK);
        chk_zero("reset_held");
        RESET_N = 1'b1;
        last_dz = 1'b0;
        run(1, 16'h3344, 16'h5566, 1'b0, 1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            p = $urandom_range(1, 3);
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            if ($urandom_range(0, 3) == 0) b = (p == 2) ? (b & 16'hFF00) : 0;
            run(p, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                1'($urandom_range(0, 3) == 0));
        end

        if0.OpValid = 1'b0;
        repeat (3) @(negedge CLK);
        chk_drained("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
